// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Read-side master for the generic bram block. A start command launches a
//   burst of `count` reads from `start_address` (wrapping modulo 2**ADDR_WIDTH).
//   Returned words pass through a small FIFO onto a valid/ready stream with a
//   last flag. The FIFO absorbs the BRAM's two-cycle read latency, so a
//   stalled sink never loses or duplicates a word.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               command strobe, sampled only while idle
//   start_address       first word address
//   count               words to read, 0..2**ADDR_WIDTH
//   busy                high from accepted start until done
//   done                one-cycle pulse when the burst is fully delivered
//   bram_en             BRAM enable (pipeline advances only while high)
//   bram_read_address   BRAM read address
//   bram_data_out       BRAM read data
//   o_valid/o_ready     stream handshake
//   o_data              stream word
//   o_last              marks the final word of the burst
//   stall_cycles        (BRAM_STREAM_READER_PERF_EN only) cycles with
//                       o_valid && !o_ready since the last start, saturating
//
// Build option
//   BRAM_STREAM_READER_PERF_EN  adds the stall_cycles counter and port.

`timescale 1ns/1ps

module bram_stream_reader #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_address,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_read_address,
    input  logic [DATA_WIDTH-1:0] bram_data_out,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last
`ifdef BRAM_STREAM_READER_PERF_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);

    localparam int unsigned FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned PTR_W      = (FIFO_DEPTH_LOG2 == 0) ? 1 : FIFO_DEPTH_LOG2;
    localparam int unsigned CNT_W      = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned SUM_W      = FIFO_DEPTH_LOG2 + 3;
    localparam int unsigned LEN_W      = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Control state
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [LEN_W-1:0]      r_remaining;
    logic                  r_en;
    logic                  r_busy;
    logic                  r_done;

    // Read pipeline tracking: r_iss_* marks the address currently presented,
    // r_tag_*[0] the word inside the BRAM, r_tag_*[1] the word on bram_data_out.
    logic                  r_iss_vld;
    logic                  r_iss_last;
    logic [1:0]            r_tag_vld;
    logic [1:0]            r_tag_last;

    // Output FIFO
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_last;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_fifo_count;
    logic                  r_o_valid;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_last_pop;
    logic [1:0]            w_inflight;
    logic [SUM_W-1:0]      w_committed;
    logic                  w_issue;
    logic                  w_start_idle;
    logic [CNT_W-1:0]      w_fifo_count_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_pop        = r_o_valid & o_ready;
    assign w_push       = r_tag_vld[1];
    assign w_last_pop   = w_pop & r_fifo_last[r_rd_ptr];
    assign w_start_idle = (r_state == S_IDLE) & start;
    assign w_inflight   = 2'(r_iss_vld) + 2'(r_tag_vld[0]) + 2'(r_tag_vld[1]);

    // Every outstanding read must already own a FIFO slot, so the new read is
    // allowed only if the words held (net of this cycle's pop) plus the reads
    // still in the BRAM pipeline leave room for one more.
    assign w_committed = SUM_W'(r_fifo_count) - SUM_W'(w_pop) + SUM_W'(w_inflight);
    assign w_issue     = (r_state == S_READ) && (r_remaining != '0) &&
                         (w_committed < SUM_W'(FIFO_DEPTH));

    assign w_fifo_count_nxt = r_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Burst FSM: command acceptance, address issue, completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_next_addr <= '0;
            r_rd_addr   <= '0;
            r_remaining <= '0;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_iss_vld   <= 1'b0;
            r_iss_last  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_iss_vld  <= 1'b0;
                    r_iss_last <= 1'b0;
                    if (start) begin
                        if (count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            // First address goes out directly on acceptance.
                            r_busy      <= 1'b1;
                            r_en        <= 1'b1;
                            r_rd_addr   <= start_address;
                            r_next_addr <= start_address + ADDR_WIDTH'(1);
                            r_remaining <= count - LEN_W'(1);
                            r_iss_vld   <= 1'b1;
                            r_iss_last  <= (count == LEN_W'(1));
                            r_state     <= (count == LEN_W'(1)) ? S_DRAIN : S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_rd_addr   <= r_next_addr;
                        r_next_addr <= r_next_addr + ADDR_WIDTH'(1);
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_iss_vld   <= 1'b1;
                        r_iss_last  <= (r_remaining == LEN_W'(1));
                        if (r_remaining == LEN_W'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end else begin
                        r_iss_vld  <= 1'b0;
                        r_iss_last <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    r_iss_vld  <= 1'b0;
                    r_iss_last <= 1'b0;
                    // The last word leaving implies pipeline and FIFO are empty.
                    if (w_last_pop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_en    <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

    // Tag shift register mirrors the BRAM pipeline, which moves only with en
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld  <= '0;
            r_tag_last <= '0;
        end else if (r_en) begin
            r_tag_vld  <= {r_tag_vld[0], r_iss_vld};
            r_tag_last <= {r_tag_last[0], r_iss_last};
        end
    end

    // Output FIFO; a pushed word is always stored before it can be popped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
            r_o_valid    <= 1'b0;
            r_fifo_last  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_fifo_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= bram_data_out;
                r_fifo_last[r_wr_ptr] <= r_tag_last[1];
                r_wr_ptr              <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_fifo_count <= w_fifo_count_nxt;
            r_o_valid    <= (w_fifo_count_nxt != '0);
        end
    end

`ifdef BRAM_STREAM_READER_PERF_EN
    logic [15:0] r_stall_cycles;

    // Backpressure counter, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_start_idle) begin
            r_stall_cycles <= '0;
        end else if (r_o_valid && !o_ready && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    logic w_unused_start_idle;
    assign w_unused_start_idle = w_start_idle;
`endif

    assign busy              = r_busy;
    assign done              = r_done;
    assign bram_en           = r_en;
    assign bram_read_address = r_rd_addr;
    assign o_valid           = r_o_valid;
    assign o_data            = r_fifo_data[r_rd_ptr];
    assign o_last            = r_fifo_last[r_rd_ptr] & r_o_valid;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Testbench for bram_stream_reader: BRAM model with two-cycle read latency,
// expected words queued at start time and checked by an independent monitor.

`timescale 1ns/1ps

module tb_bram_stream_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_address;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic          bram_en;
    logic [AW-1:0] bram_read_address;
    logic [DW-1:0] bram_data_out;
    logic          o_valid;
    logic          o_ready;
    logic [DW-1:0] o_data;
    logic          o_last;
`ifdef BRAM_STREAM_READER_PERF_EN
    logic [15:0]   stall_cycles;
`endif

    always #5 clk = ~clk;

    bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH_LOG2(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .start_address     (start_address),
        .count             (count),
        .busy              (busy),
        .done              (done),
        .bram_en           (bram_en),
        .bram_read_address (bram_read_address),
        .bram_data_out     (bram_data_out),
        .o_valid           (o_valid),
        .o_ready           (o_ready),
        .o_data            (o_data),
        .o_last            (o_last)
`ifdef BRAM_STREAM_READER_PERF_EN
        ,
        .stall_cycles      (stall_cycles)
`endif
    );

    // BRAM model: address captured at one edge, data out at the next
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] bram_s1;
    always @(posedge clk) begin
        if (bram_en) begin
            bram_s1       <= mem[bram_read_address];
            bram_data_out <= bram_s1;
        end
    end

    int            n_vec    = 0;
    int            n_err    = 0;
    int            n_popped = 0;
    logic [DW:0]   exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_burst(input logic [AW-1:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] ad;
            ad = a + AW'(i);
            exp_q.push_back({(i == n - 1), mem[ad]});
        end
    endtask

    // Monitor: compares each handshaken word with the scoreboard head
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(o_valid), 64'd1);
                chk("hold_data", 64'(o_data), 64'(prev_data));
                chk("hold_last", 64'(o_last), 64'(prev_last));
            end
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got 0x%0h expected no word", o_data);
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    chk("word_data", 64'(o_data), 64'(e[DW-1:0]));
                    chk("word_last", 64'(o_last), 64'(e[DW]));
                end
                n_popped++;
            end
            prev_stall = o_valid && !o_ready;
            prev_data  = o_data;
            prev_last  = o_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] a, input logic [AW:0] n);
        start         = 1'b1;
        start_address = a;
        count         = n;
        tick();
        start         = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int cyc);
        cyc = 0;
        while (!done && cyc < bound) begin
            tick();
            cyc++;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", bound);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_bram_en"}, 64'(bram_en), 64'd0);
        chk({tag, "_addr"}, 64'(bram_read_address), 64'd0);
        chk({tag, "_o_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_o_data"}, 64'(o_data), 64'd0);
        chk({tag, "_o_last"}, 64'(o_last), 64'd0);
    endtask

    int            cyc;
    int            base;
    logic [AW-1:0] t2_exp [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'(i) + 32'h100;
        t2_exp[0] = 10'h3FE; t2_exp[1] = 10'h3FF; t2_exp[2] = 10'h000; t2_exp[3] = 10'h001;
        rst = 1'b1; start = 1'b0; start_address = '0; count = '0; o_ready = 1'b1;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // 1: 8 words from 0x010 at full rate
        expect_burst(10'h010, 8);
        do_start(10'h010, 11'd8);
        cyc = 0;
        while (!o_valid && cyc < 20) begin tick(); cyc++; end
        chk("t1_first_valid_latency", 64'(cyc), 64'd3);
        wait_done(40, cyc);
        chk("t1_done_after_first_valid", 64'(cyc), 64'd8);
        chk("t1_busy_at_done", 64'(busy), 64'd0);
        tick();
        chk("t1_done_one_cycle", 64'(done), 64'd0);
        chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // 2: address wrap 3FE,3FF,000,001
        expect_burst(10'h3FE, 4);
        do_start(10'h3FE, 11'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_addr", 64'(bram_read_address), 64'(t2_exp[i]));
            tick();
        end
        wait_done(40, cyc);
        tick();
        chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // 3: 32 words, 10-cycle stall then random backpressure
        expect_burst(10'h040, 32);
        do_start(10'h040, 11'd32);
        cyc = 0;
        while (!done && cyc < 600) begin
            if (cyc < 8)       o_ready = 1'b1;
            else if (cyc < 18) o_ready = 1'b0;
            else               o_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        chk("t3_done_seen", 64'(done), 64'd1);
        o_ready = 1'b1;
        tick();
        chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // 4: zero-length command
        do_start(10'h055, 11'd0);
        chk("t4_done_pulse", 64'(done), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_en", 64'(bram_en), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_no_valid", 64'(o_valid), 64'd0);
            chk("t4_busy_low", 64'(busy), 64'd0);
        end

        // 5: reset after 3 of 16 words, then a fresh 2-word burst
        base = n_popped;
        expect_burst(10'h080, 16);
        do_start(10'h080, 11'd16);
        cyc = 0;
        while ((n_popped - base) < 3 && cyc < 50) begin tick(); cyc++; end
        chk("t5_words_before_reset", 64'(n_popped - base), 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("t5_after_reset");
        exp_q.delete();
        tick();
        expect_burst(10'h200, 2);
        do_start(10'h200, 11'd2);
        wait_done(40, cyc);
        repeat (3) tick();
        chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        // 6: start while busy is ignored; stall counting
        o_ready = 1'b0;
        expect_burst(10'h000, 6);
        do_start(10'h000, 11'd6);
        cyc = 0;
        while (!o_valid && cyc < 20) begin tick(); cyc++; end
        chk("t6_first_valid_latency", 64'(cyc), 64'd3);
        start = 1'b1; start_address = 10'h100; count = 11'd3;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("t6_busy_during_stall", 64'(busy), 64'd1);
`ifdef BRAM_STREAM_READER_PERF_EN
        chk("t6_stall_cycles", 64'(stall_cycles), 64'd5);
`endif
        o_ready = 1'b1;
        wait_done(60, cyc);
        repeat (4) tick();
        chk("t6_no_second_burst", 64'(busy), 64'd0);
        chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef BRAM_STREAM_READER_PERF_EN
        chk("t6_stall_cycles_final", 64'(stall_cycles), 64'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
